// File: rtl/mio_responder.sv
// mio_responder: memory/IO bus responder for the multi-cycle CPU controller.
// A qualified request waits WAIT_CYCLES states, is serviced from word RAM or
// one of three IO registers, and completes with a one-cycle MIO_ready pulse.
module mio_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CPU_MIO,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_write,
    input  logic [15:0] sw_in,
    output logic [31:0] Data_read,
    output logic        MIO_ready,
    output logic [15:0] led_out,
    output logic        bus_err
);
    localparam int          DEPTH     = 2 ** ADDR_W;
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);
    // IO register word addresses (byte address >> 2)
    localparam logic [29:0] IO_LED    = 30'h3C00_0000;
    localparam logic [29:0] IO_SW     = 30'h3C00_0001;
    localparam logic [29:0] IO_CYC    = 30'h3C00_0002;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [31:0]       cyc_q, cyc_d;
    logic [31:0]       data_read_q, data_read_d;
    logic              mio_ready_q, mio_ready_d;
    logic [15:0]       led_q, led_d;
    logic              bus_err_q, bus_err_d;
    logic [31:0]       ram_q [DEPTH];

    logic              req;
    logic              is_io;
    logic              wr_only;
    logic              in_access;
    logic              enter_access;
    logic              ram_we;
    logic [29:0]       word_addr;
    logic [ADDR_W-1:0] ram_idx;
    logic [31:0]       rd_data;
    logic              unused_addr_lsb;

    assign req             = CPU_MIO & (MemRead | MemWrite);
    assign is_io           = (Addr_in[31:28] == 4'hF);
    assign word_addr       = Addr_in[31:2];
    assign ram_idx         = Addr_in[ADDR_W+1:2];
    assign wr_only         = MemWrite & ~MemRead;   // read wins on a conflicting request
    assign in_access       = (state_q == S_ACCESS);
    assign unused_addr_lsb = ^Addr_in[1:0];

    // Request sequencing: IDLE -> WAIT (countdown, abort on dropped request) -> ACCESS -> DONE
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d    = S_WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d    = S_IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == 4'd1) begin
                    state_d    = S_ACCESS;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            S_ACCESS: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Cycle counter: free-running, cleared by a write to its IO address
    always_comb begin
        cyc_d = cyc_q + 32'd1;
        if (in_access && wr_only && word_addr == IO_CYC) begin
            cyc_d = '0;
        end
    end

    // Read mux; the counter reads as its value during the ready cycle
    always_comb begin
        rd_data = '0;
        if (!is_io) begin
            rd_data = ram_q[ram_idx];
        end else if (word_addr == IO_LED) begin
            rd_data = {16'h0, led_q};
        end else if (word_addr == IO_SW) begin
            rd_data = {16'h0, sw_in};
        end else if (word_addr == IO_CYC) begin
            rd_data = cyc_d;
        end
    end

    // Read data and ready are captured on entry to ACCESS; writes commit as ACCESS ends
    always_comb begin
        enter_access = (state_d == S_ACCESS);
        mio_ready_d  = enter_access;
        data_read_d  = data_read_q;
        if (enter_access && MemRead) begin
            data_read_d = rd_data;
        end
        bus_err_d = bus_err_q | (enter_access & MemRead & MemWrite);
        led_d     = led_q;
        if (in_access && wr_only && word_addr == IO_LED) begin
            led_d = Data_write[15:0];
        end
        ram_we = in_access && wr_only && !is_io;
    end

    // Control and output registers, asynchronously cleared
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            cyc_q       <= '0;
            data_read_q <= '0;
            mio_ready_q <= 1'b0;
            led_q       <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            cyc_q       <= cyc_d;
            data_read_q <= data_read_d;
            mio_ready_q <= mio_ready_d;
            led_q       <= led_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Word RAM; contents survive reset, and reset blocks the write via the state register
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= Data_write;
        end
    end

    assign Data_read = data_read_q;
    assign MIO_ready = mio_ready_q;
    assign led_out   = led_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mio_responder.sv
// Testbench for mio_responder: randomized bus traffic against a behavioural
// model of RAM, IO registers, timing and the cycle counter.
`timescale 1ns/1ps
module tb_mio_responder;
    localparam int ADDR_W = 8;
    localparam int W      = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        CPU_MIO;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Addr_in;
    logic [31:0] Data_write;
    logic [15:0] sw_in;
    logic [31:0] Data_read;
    logic        MIO_ready;
    logic [15:0] led_out;
    logic        bus_err;

    mio_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset), .CPU_MIO(CPU_MIO), .MemRead(MemRead),
        .MemWrite(MemWrite), .Addr_in(Addr_in), .Data_write(Data_write),
        .sw_in(sw_in), .Data_read(Data_read), .MIO_ready(MIO_ready),
        .led_out(led_out), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Serial number of rising edges, used to time the cycle-counter model
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ram_m [int];
    logic [15:0] led_m;
    logic        err_m;
    logic [31:0] last_rd;

    function automatic int widx(logic [31:0] a);
        return int'(a[ADDR_W+1:2]);
    endfunction

    function automatic logic [31:0] model_read(logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (a[31:28] == 4'hF) begin
            if (wa == 32'hF000_0000) return {16'h0, led_m};
            if (wa == 32'hF000_0004) return {16'h0, sw_in};
            return 32'h0;
        end
        if (ram_m.exists(widx(a))) return ram_m[widx(a)];
        return 'x;
    endfunction

    function automatic void model_write(logic [31:0] a, logic [31:0] d);
        if (a[31:28] == 4'hF) begin
            if ({a[31:2], 2'b00} == 32'hF000_0000) led_m = d[15:0];
        end else begin
            ram_m[widx(a)] = d;
        end
    endfunction

    function automatic logic [31:0] rand_ram_addr(int idx);
        logic [31:0] hi;
        hi = $urandom & 32'hEFFF_FFFF;
        hi = (hi >> (ADDR_W + 2)) << (ADDR_W + 2);
        return hi | (32'(idx) << 2);
    endfunction

    // One complete bus transaction; returns observations only
    task automatic bus_op(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output int lat, output int req_edge, output bit extra_ready);
        @(negedge clk);
        CPU_MIO = 1'b1; MemRead = rd; MemWrite = wr; Addr_in = addr; Data_write = wdata;
        req_edge = edge_cnt + 1;
        lat = -1;
        rdata = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (MIO_ready) begin
                lat = k;
                rdata = Data_read;
                break;
            end
        end
        @(negedge clk);
        extra_ready = MIO_ready;
        CPU_MIO = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; CPU_MIO = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        Addr_in = '0; Data_write = '0; sw_in = '0;
        repeat (3) @(negedge clk);
        checks++; if (Data_read !== 32'h0) begin errors++; $display("FAIL reset_data_read: got %h want 0", Data_read); end
        checks++; if (MIO_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", MIO_ready); end
        checks++; if (led_out !== 16'h0) begin errors++; $display("FAIL reset_led: got %h want 0", led_out); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
        reset = 1'b1;
        led_m = '0; err_m = 1'b0; last_rd = '0;
    endtask

    task automatic test_ram_rw();
        logic [31:0] rd; int lat, re; bit xr;
        bus_op(1'b0, 1'b1, 32'h10, 32'h1234_5678, rd, lat, re, xr);
        model_write(32'h10, 32'h1234_5678);
        checks++; if (lat !== W + 1) begin errors++; $display("FAIL ram_wr_latency: got %0d want %0d", lat, W + 1); end
        checks++; if (xr !== 1'b0) begin errors++; $display("FAIL ram_wr_pulse_width: ready still %b want 0", xr); end
        checks++; if (Data_read !== last_rd) begin errors++; $display("FAIL ram_wr_data_read_held: got %h want %h", Data_read, last_rd); end
        bus_op(1'b1, 1'b0, 32'h10, 32'h0, rd, lat, re, xr);
        checks++; if (lat !== W + 1) begin errors++; $display("FAIL ram_rd_latency: got %0d want %0d", lat, W + 1); end
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL ram_rd_data: got %h want 12345678", rd); end
        last_rd = model_read(32'h10);
    endtask

    task automatic test_io();
        logic [31:0] rd; int lat, re; bit xr;
        bus_op(1'b0, 1'b1, 32'hF000_0000, 32'hAAAA_BEEF, rd, lat, re, xr);
        model_write(32'hF000_0000, 32'hAAAA_BEEF);
        checks++; if (led_out !== 16'hBEEF) begin errors++; $display("FAIL io_led_write: got %h want beef", led_out); end
        sw_in = 16'h00C3;
        bus_op(1'b1, 1'b0, 32'hF000_0004, 32'h0, rd, lat, re, xr);
        checks++; if (rd !== 32'h0000_00C3) begin errors++; $display("FAIL io_sw_read: got %h want 000000c3", rd); end
        bus_op(1'b1, 1'b0, 32'hF000_0000, 32'h0, rd, lat, re, xr);
        checks++; if (rd !== model_read(32'hF000_0000)) begin errors++; $display("FAIL io_led_read: got %h want %h", rd, model_read(32'hF000_0000)); end
        bus_op(1'b0, 1'b1, 32'hF000_0004, 32'hFFFF_FFFF, rd, lat, re, xr);
        bus_op(1'b1, 1'b0, 32'hF000_0004, 32'h0, rd, lat, re, xr);
        checks++; if (rd !== 32'h0000_00C3) begin errors++; $display("FAIL io_sw_readonly: got %h want 000000c3", rd); end
        checks++; if (led_out !== 16'hBEEF) begin errors++; $display("FAIL io_led_untouched: got %h want beef", led_out); end
        bus_op(1'b1, 1'b0, 32'hF000_0040, 32'h0, rd, lat, re, xr);
        checks++; if (lat !== W + 1) begin errors++; $display("FAIL io_unmapped_latency: got %0d want %0d", lat, W + 1); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL io_unmapped_read: got %h want 0", rd); end
        last_rd = 32'h0;
    endtask

    task automatic test_alias();
        logic [31:0] rd; int lat, re; bit xr;
        bus_op(1'b1, 1'b0, 32'h10 + 4 * (2 ** ADDR_W), 32'h0, rd, lat, re, xr);
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL alias_read: got %h want 12345678", rd); end
        bus_op(1'b0, 1'b1, 32'h8000_000C | (32'h5 << (ADDR_W + 2)), 32'h5555_AAAA, rd, lat, re, xr);
        model_write(32'h8000_000C, 32'h5555_AAAA);
        bus_op(1'b1, 1'b0, 32'h0000_000C, 32'h0, rd, lat, re, xr);
        checks++; if (rd !== model_read(32'hC)) begin errors++; $display("FAIL alias_write: got %h want %h", rd, model_read(32'hC)); end
        last_rd = model_read(32'hC);
    endtask

    task automatic test_abort();
        logic [31:0] rd; int lat, re; bit xr; bit seen;
        @(negedge clk);
        CPU_MIO = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; Addr_in = 32'h10; Data_write = 32'hDEAD_DEAD;
        repeat ($urandom_range(1, W)) @(negedge clk);
        CPU_MIO = 1'b0;
        seen = 1'b0;
        repeat (6) begin @(negedge clk); if (MIO_ready) seen = 1'b1; end
        MemWrite = 1'b0; MemRead = 1'b1;
        repeat (6) begin @(negedge clk); if (MIO_ready) seen = 1'b1; end
        MemRead = 1'b0;
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_ready: got ready %b want 0", seen); end
        bus_op(1'b1, 1'b0, 32'h10, 32'h0, rd, lat, re, xr);
        checks++; if (lat !== W + 1) begin errors++; $display("FAIL abort_back_to_idle: latency %0d want %0d", lat, W + 1); end
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL abort_ram_unchanged: got %h want 12345678", rd); end
        last_rd = rd;
    endtask

    task automatic test_conflict();
        logic [31:0] rd; int lat, re; bit xr;
        checks++; if (bus_err !== err_m) begin errors++; $display("FAIL conflict_pre_err: got %b want %b", bus_err, err_m); end
        bus_op(1'b1, 1'b1, 32'h10, 32'h0, rd, lat, re, xr);
        err_m = 1'b1;
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL conflict_read: got %h want 12345678", rd); end
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL conflict_err_set: got %b want 1", bus_err); end
        bus_op(1'b1, 1'b0, 32'h10, 32'h0, rd, lat, re, xr);
        checks++; if (rd !== model_read(32'h10)) begin errors++; $display("FAIL conflict_no_write: got %h want %h", rd, model_read(32'h10)); end
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL conflict_err_sticky: got %b want 1", bus_err); end
        last_rd = rd;
    endtask

    task automatic test_counter();
        logic [31:0] rd, expv; int lat, re_w, re_r; bit xr;
        bus_op(1'b0, 1'b1, 32'hF000_0008, $urandom, rd, lat, re_w, xr);
        checks++; if (Data_read !== last_rd) begin errors++; $display("FAIL counter_wr_data_held: got %h want %h", Data_read, last_rd); end
        for (int i = 0; i < 2; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            bus_op(1'b1, 1'b0, 32'hF000_0008, 32'h0, rd, lat, re_r, xr);
            expv = 32'(re_r - re_w - 1);
            checks++; if (rd !== expv) begin errors++; $display("FAIL counter_read%0d: got %0d want %0d", i, rd, expv); end
            last_rd = expv;
        end
    endtask

    task automatic test_back_to_back();
        int pos[$];
        @(negedge clk);
        CPU_MIO = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Addr_in = 32'h10;
        for (int k = 1; k <= 4 * (W + 3) + 2 && pos.size() < 3; k++) begin
            @(negedge clk);
            if (MIO_ready) begin
                pos.push_back(k);
                checks++; if (Data_read !== model_read(32'h10)) begin errors++; $display("FAIL b2b_data: got %h want %h", Data_read, model_read(32'h10)); end
            end
        end
        @(negedge clk);
        CPU_MIO = 1'b0; MemRead = 1'b0;
        last_rd = model_read(32'h10);
        checks++;
        if (pos.size() != 3) begin
            errors++; $display("FAIL b2b_pulse_count: got %0d want 3", pos.size());
        end else begin
            checks++; if (pos[0] != W + 1) begin errors++; $display("FAIL b2b_first_latency: got %0d want %0d", pos[0], W + 1); end
            checks++; if (pos[1] - pos[0] != W + 3) begin errors++; $display("FAIL b2b_spacing1: got %0d want %0d", pos[1] - pos[0], W + 3); end
            checks++; if (pos[2] - pos[1] != W + 3) begin errors++; $display("FAIL b2b_spacing2: got %0d want %0d", pos[2] - pos[1], W + 3); end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, d, expv; int lat, re, op; bit xr;
        for (int i = 0; i < 8; i++) begin
            a = rand_ram_addr(i); d = $urandom;
            bus_op(1'b0, 1'b1, a, d, rd, lat, re, xr);
            model_write(a, d);
        end
        for (int n = 0; n < 30; n++) begin
            op = $urandom_range(0, 4);
            a = (op < 2) ? rand_ram_addr($urandom_range(0, 7)) : ((op == 4) ? 32'hF000_0004 : 32'hF000_0000);
            d = $urandom;
            if (op == 4) sw_in = 16'($urandom);
            if (op == 0 || op == 2) begin
                bus_op(1'b0, 1'b1, a, d, rd, lat, re, xr);
                model_write(a, d);
                checks++; if (Data_read !== last_rd) begin errors++; $display("FAIL rnd_wr_held[%0d]: got %h want %h", n, Data_read, last_rd); end
            end else begin
                expv = model_read(a);
                bus_op(1'b1, 1'b0, a, 32'h0, rd, lat, re, xr);
                checks++; if (rd !== expv) begin errors++; $display("FAIL rnd_rd[%0d] @%h: got %h want %h", n, a, rd, expv); end
                last_rd = expv;
            end
            checks++; if (lat !== W + 1) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", n, lat, W + 1); end
        end
        checks++; if (led_out !== led_m) begin errors++; $display("FAIL rnd_led: got %h want %h", led_out, led_m); end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd, old; int lat, re; bit xr; bit seen;
        old = model_read(32'h14);
        @(negedge clk);
        CPU_MIO = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; Addr_in = 32'h14; Data_write = ~old;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (Data_read !== 32'h0) begin errors++; $display("FAIL async_rst_data_read: got %h want 0", Data_read); end
        checks++; if (led_out !== 16'h0) begin errors++; $display("FAIL async_rst_led: got %h want 0", led_out); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL async_rst_bus_err: got %b want 0", bus_err); end
        checks++; if (MIO_ready !== 1'b0) begin errors++; $display("FAIL async_rst_ready: got %b want 0", MIO_ready); end
        seen = 1'b0;
        repeat (3) begin @(negedge clk); if (MIO_ready) seen = 1'b1; end
        CPU_MIO = 1'b0; MemWrite = 1'b0;
        reset = 1'b1;
        repeat (4) begin @(negedge clk); if (MIO_ready) seen = 1'b1; end
        led_m = '0; err_m = 1'b0; last_rd = '0;
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_no_ready: got %b want 0", seen); end
        bus_op(1'b1, 1'b0, 32'h14, 32'h0, rd, lat, re, xr);
        checks++; if (rd !== old) begin errors++; $display("FAIL rst_no_write: got %h want %h", rd, old); end
        checks++; if (lat !== W + 1) begin errors++; $display("FAIL rst_latency: got %0d want %0d", lat, W + 1); end
        checks++; if (bus_err !== err_m) begin errors++; $display("FAIL rst_bus_err_after: got %b want %b", bus_err, err_m); end
    endtask

    initial begin
        test_reset();
        test_ram_rw();
        test_io();
        test_alias();
        test_abort();
        test_conflict();
        test_counter();
        test_back_to_back();
        test_random();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
